mips_dmem_responder: RTL and testbench
======================================

Name: mips_dmem_responder

Overview:
Data-memory responder for the MIPS core's load/store port. It accepts one word-aligned read or write request at a time over a valid/ready handshake, applies byte enables on stores, and returns a registered response after a fixed, parameterised latency. It sits between the CPU memory stage and the on-chip data SRAM, replacing combinational array access with a timed, back-pressurable interface.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words in the data array; must be a power of two.
LATENCY, 2, cycles from request acceptance to rsp_valid; legal range 1..15.

Ports:
clk  input  1  clock; all logic is on the rising edge.
reset  input  1  synchronous, active-low reset (asserted when 0).
req_valid  input  1  request present.
req_ready  output  1  responder can accept a request.
req_we  input  1  1 = store, 0 = load.
req_addr  input  32  byte address.
req_wdata  input  32  store data.
req_be  input  4  store byte enables; bit i selects byte i (bits 8i+7:8i).
rsp_valid  output  1  response present.
rsp_ready  input  1  requester accepts the response.
rsp_rdata  output  32  load data; 0 for stores and errors.
rsp_err  output  1  request was misaligned or out of range.

Behaviour:
- Reset (reset==0 at a clk edge): state=IDLE, req_ready=0 during reset and 1 on the first cycle after, rsp_valid=0, rsp_rdata=0, rsp_err=0, latency counter=0. Array contents are not cleared.
- FSM states:
  - IDLE: req_ready=1, rsp_valid=0.
  - WAIT: req_ready=0, counter running.
  - RESP: req_ready=0, rsp_valid=1.
- Acceptance: a request is accepted on an edge where req_valid & req_ready. Requests and their fields are sampled only at that edge, so fields may change afterwards.
- Error check at acceptance: err = (req_addr[1:0] != 0) or (req_addr>>2 >= DEPTH_WORDS).
- Store at acceptance, no error:
  - The array word at index req_addr>>2 is updated on that same edge, byte-wise per req_be.
  - req_be=0 writes nothing but still produces a normal response.
- Load at acceptance, no error: the array word is read and captured into the response data register on that edge.
- Error: no array write; captured rdata=0, err=1.
- Stores always return rdata=0.
- Latency:
  - Acceptance at edge T puts rsp_valid=1 in the cycle following edge T+LATENCY-1.
  - LATENCY=1 goes IDLE to RESP directly. The first rsp_valid cycle is the cycle right after acceptance.
  - LATENCY>1: IDLE to WAIT with counter=LATENCY-2, decrement each edge, WAIT to RESP when counter==0.
- Response hold: in RESP, rsp_valid, rsp_rdata and rsp_err are held stable until an edge with rsp_ready=1. On that edge: RESP to IDLE, rsp_valid=0, rsp_rdata and rsp_err cleared to 0.
- Throughput: one outstanding request. The next acceptance can occur no earlier than the cycle after the response handshake. A store followed by a load to the same word always returns the stored data.
- rsp_ready asserted outside RESP is ignored. req_valid outside IDLE is ignored, and the requester must hold it.
- Reset mid-operation: any in-flight response is discarded and never presented. A store accepted before reset remains committed in the array.
- Address wrap: none. Out-of-range addresses error and never alias.

Decomposition:
- Package mips_mem_pkg holds:
  - the state enum (IDLE, WAIT, RESP);
  - WORD_W=32;
  - BE_W=4;
  - a function computing the word index from a byte address.
- One sub-module, dmem_array: a synchronous single-port 32-bit RAM with byte-enable write and a registered read, DEPTH_WORDS deep.
- The FSM, counter and response registers stay in mips_dmem_responder.

Test Plan:
- Reset, then store addr=0x10, wdata=0xDEADBEEF, be=4'hF, followed by a load from 0x10 with LATENCY=2. Required: each response appears 2 cycles after acceptance, with rsp_err=0. The load returns 0xDEADBEEF.
- Byte-enable merge: store 0x11223344 be=F to 0x20, then 0xAABBCCDD be=4'b0101 to 0x20, then load 0x20. Required: 0x11BB33DD.
- Errors:
  - Load 0x22 (misaligned). Required: rsp_err=1, rdata=0.
  - Store to 0x400 with DEPTH_WORDS=256. Required: rsp_err=1, and a later load of 0x0 still returns its prior value.
- Backpressure: hold rsp_ready=0 for 5 cycles during a load of a word containing 0xCAFEF00D. Required: rsp_valid and rsp_rdata stable for all 5 cycles, req_ready=0 throughout, and IDLE with req_ready=1 the cycle after rsp_ready=1.
- LATENCY=1 back-to-back: 4 loads with rsp_ready tied high. Required: one acceptance every 2 cycles, and each response the cycle after its acceptance.
- Reset mid-WAIT: accept a store of 0x5A5A5A5A to 0x8, then drive reset low one cycle later. Required: no rsp_valid appears. After reset, a load of 0x8 returns 0x5A5A5A5A.

Source files
------------

// File: rtl/mips_dmem_responder_pkg.sv
// Shared types and helpers for the MIPS data-memory responder.
// Holds the FSM state encoding, bus widths and byte-address to word-index mapping.
package mips_mem_pkg;

    localparam int WORD_W = 32;
    localparam int BE_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic [29:0] word_index(input logic [31:0] byte_addr);
        return byte_addr[31:2];
    endfunction

endpackage

// File: rtl/mips_dmem_responder_if.sv
// Load/store request and response handshake between the CPU memory stage and the responder.
// The master drives requests and rsp_ready; the slave answers with req_ready and the response.
interface mips_dmem_if;
    import mips_mem_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [31:0]       req_addr;
    logic [WORD_W-1:0] req_wdata;
    logic [BE_W-1:0]   req_be;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [WORD_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/mips_dmem_responder_array.sv
// Single-port data SRAM: byte-enable write and registered read on the same edge as the access.
// The read register holds its value until the next read access.
module dmem_array
    import mips_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = 8
) (
    input  logic              clk,
    input  logic              i_en,
    input  logic              i_we,
    input  logic [BE_W-1:0]   i_be,
    input  logic [AW-1:0]     i_addr,
    input  logic [WORD_W-1:0] i_wdata,
    output logic [WORD_W-1:0] o_rdata
);

    logic [WORD_W-1:0] r_mem [DEPTH_WORDS];
    logic [WORD_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) begin
                for (int b = 0; b < BE_W; b++) begin
                    if (i_be[b]) begin
                        r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                    end
                end
            end else begin
                r_rdata <= r_mem[i_addr];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/mips_dmem_responder.sv
// Timed, back-pressurable data-memory responder: one outstanding word access,
// response presented LATENCY cycles after acceptance and held until rsp_ready.
module mips_dmem_responder
    import mips_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic         clk,
    input  logic         reset,
    mips_dmem_if.slave   bus
);

    localparam int         AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    state_t            r_state;
    logic [3:0]        r_cnt;
    logic              r_req_rdy;
    logic              r_rsp_vld;
    logic              r_rsp_err;
    logic              r_rsp_load;
    logic              r_pend_err;
    logic              r_pend_load;

    logic              w_accept;
    logic              w_err;
    logic              w_ram_en;
    logic [29:0]       w_idx;
    logic [WORD_W-1:0] w_ram_q;

    // Gating with reset keeps a request at a reset edge from touching the array.
    assign w_accept = bus.req_valid & r_req_rdy & reset;
    assign w_idx    = word_index(bus.req_addr);
    assign w_err    = (bus.req_addr[1:0] != 2'b00) || ({2'b00, w_idx} >= 32'(DEPTH_WORDS));
    assign w_ram_en = w_accept & ~w_err;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk     (clk),
        .i_en    (w_ram_en),
        .i_we    (bus.req_we),
        .i_be    (bus.req_be),
        .i_addr  (w_idx[AW-1:0]),
        .i_wdata (bus.req_wdata),
        .o_rdata (w_ram_q)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_cnt       <= 4'd0;
            r_req_rdy   <= 1'b0;
            r_rsp_vld   <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_load  <= 1'b0;
            r_pend_err  <= 1'b0;
            r_pend_load <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_req_rdy   <= 1'b0;
                        r_pend_err  <= w_err;
                        r_pend_load <= ~bus.req_we & ~w_err;
                        if (LATENCY == 1) begin
                            r_state    <= RESP;
                            r_rsp_vld  <= 1'b1;
                            r_rsp_err  <= w_err;
                            r_rsp_load <= ~bus.req_we & ~w_err;
                        end else begin
                            r_state <= WAIT;
                            r_cnt   <= CNT_INIT;
                        end
                    end else begin
                        r_req_rdy <= 1'b1;
                    end
                end
                WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state    <= RESP;
                        r_rsp_vld  <= 1'b1;
                        r_rsp_err  <= r_pend_err;
                        r_rsp_load <= r_pend_load;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        r_state     <= IDLE;
                        r_req_rdy   <= 1'b1;
                        r_rsp_vld   <= 1'b0;
                        r_rsp_err   <= 1'b0;
                        r_rsp_load  <= 1'b0;
                        r_pend_err  <= 1'b0;
                        r_pend_load <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_req_rdy <= 1'b0;
                    r_rsp_vld <= 1'b0;
                end
            endcase
        end
    end

    // The array read register is only disturbed by another accepted load, so it stays valid through RESP.
    assign bus.req_ready = r_req_rdy;
    assign bus.rsp_valid = r_rsp_vld;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.rsp_rdata = r_rsp_load ? w_ram_q : '0;

endmodule

// File: tb/tb_mips_dmem_responder.sv
// Scoreboard bench: two responders (LATENCY 2 and 1) driven with directed and random
// traffic, checked against a word-array reference model by per-instance monitors.
module tb_mips_dmem_responder;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic rst_q = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rst_q <= rst_n;

    logic        d_vld   [2];
    logic        d_we    [2];
    logic [31:0] d_addr  [2];
    logic [31:0] d_wdata [2];
    logic [3:0]  d_be    [2];
    logic        m_rdy   [2];

    exp_t        expq  [2][$];
    logic [31:0] mem_m [2][256];

    mips_dmem_if bus [2] ();

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : gen_dut
        localparam int L = (g == 0) ? 2 : 1;

        logic        rrdy = 1'b0;
        logic        in_rsp = 1'b0;
        logic        hs_pend = 1'b0;
        int          hold_left = 0;
        int          hold_req = 0;
        logic [31:0] h_rdata;
        logic        h_err;
        exp_t        e;

        assign bus[g].req_valid = d_vld[g];
        assign bus[g].req_we    = d_we[g];
        assign bus[g].req_addr  = d_addr[g];
        assign bus[g].req_wdata = d_wdata[g];
        assign bus[g].req_be    = d_be[g];
        assign bus[g].rsp_ready = rrdy;
        assign m_rdy[g]         = bus[g].req_ready;

        mips_dmem_responder #(
            .DEPTH_WORDS (256),
            .LATENCY     (L)
        ) u_dut (
            .clk   (clk),
            .reset (rst_n),
            .bus   (bus[g])
        );

        always @(negedge clk) begin
            if (!rst_q) begin
                chk("rst_rsp_valid", 32'(bus[g].rsp_valid), 32'd0);
                chk("rst_req_ready", 32'(bus[g].req_ready), 32'd0);
                chk("rst_rsp_rdata", bus[g].rsp_rdata, 32'd0);
                chk("rst_rsp_err", 32'(bus[g].rsp_err), 32'd0);
                in_rsp  = 1'b0;
                hs_pend = 1'b0;
                rrdy    = 1'b0;
            end else begin
                if (hs_pend) begin
                    chk("post_hs_valid", 32'(bus[g].rsp_valid), 32'd0);
                    chk("post_hs_rdata", bus[g].rsp_rdata, 32'd0);
                    chk("post_hs_err", 32'(bus[g].rsp_err), 32'd0);
                    chk("post_hs_req_ready", 32'(bus[g].req_ready), 32'd1);
                    hs_pend = 1'b0;
                    in_rsp  = 1'b0;
                end
                if (bus[g].rsp_valid === 1'b1) begin
                    if (!in_rsp) begin
                        if (expq[g].size() == 0) begin
                            n_tests++;
                            n_fail++;
                            $display("FAIL unexpected_rsp: dut%0d rsp_valid=1 with no outstanding request (cycle %0d)", g, cyc);
                        end else begin
                            e = expq[g].pop_front();
                            chk("rsp_rdata", bus[g].rsp_rdata, e.rdata);
                            chk("rsp_err", 32'(bus[g].rsp_err), 32'(e.err));
                            chk("rsp_cycle", cyc, e.acc + L - 1);
                        end
                        h_rdata = bus[g].rsp_rdata;
                        h_err   = bus[g].rsp_err;
                        in_rsp  = 1'b1;
                        if (hold_req > 0) hold_left = hold_req;
                        else hold_left = (g == 0) ? $urandom_range(0, 2) : 0;
                        hold_req = 0;
                    end else begin
                        chk("hold_rdata", bus[g].rsp_rdata, h_rdata);
                        chk("hold_err", 32'(bus[g].rsp_err), 32'(h_err));
                    end
                    chk("req_ready_in_rsp", 32'(bus[g].req_ready), 32'd0);
                    if (hold_left > 0) begin
                        rrdy = 1'b0;
                        hold_left--;
                    end else begin
                        rrdy    = 1'b1;
                        hs_pend = 1'b1;
                    end
                end else begin
                    if (in_rsp) begin
                        chk("rsp_valid_held", 32'(bus[g].rsp_valid), 32'd1);
                        in_rsp = 1'b0;
                    end
                    rrdy = 1'($urandom_range(0, 1));
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input int s, input logic we, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] be, output int acc);
        exp_t        e;
        int          budget;
        int          idx;
        logic [31:0] mask;
        logic        ok;
        d_vld[s]   = 1'b1;
        d_we[s]    = we;
        d_addr[s]  = addr;
        d_wdata[s] = wd;
        d_be[s]    = be;
        budget = 0;
        ok     = 1'b1;
        while (m_rdy[s] !== 1'b1) begin
            @(negedge clk);
            budget++;
            if (budget > 100) begin
                n_tests++;
                n_fail++;
                $display("FAIL req_timeout: dut%0d req_ready stuck at %b, required 1", s, m_rdy[s]);
                ok = 1'b0;
                break;
            end
        end
        acc = cyc + 1;
        if (ok) begin
            idx     = int'(addr >> 2);
            e.err   = (addr[1:0] != 2'b00) || (idx >= 256);
            e.acc   = acc;
            e.rdata = 32'd0;
            if (!e.err && we) begin
                mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
                mem_m[s][idx] = (mem_m[s][idx] & ~mask) | (wd & mask);
            end else if (!e.err) begin
                e.rdata = mem_m[s][idx];
            end
            expq[s].push_back(e);
        end
        @(negedge clk);
        d_vld[s]   = 1'b0;
        d_we[s]    = 1'($urandom_range(0, 1));
        d_addr[s]  = $urandom();
        d_wdata[s] = $urandom();
        d_be[s]    = 4'($urandom_range(0, 15));
    endtask

    initial begin
        int          a;
        int          accs [4];
        logic [31:0] ra;
        for (int s = 0; s < 2; s++) begin
            d_vld[s] = 1'b0; d_we[s] = 1'b0; d_addr[s] = '0; d_wdata[s] = '0; d_be[s] = '0;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 256; i++) issue(0, 1'b1, 32'(i * 4), $urandom(), 4'hF, a);

        issue(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, a);
        issue(0, 1'b0, 32'h10, 32'h0, 4'h0, a);
        issue(0, 1'b1, 32'h20, 32'h11223344, 4'hF, a);
        issue(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, a);
        issue(0, 1'b0, 32'h20, 32'h0, 4'h0, a);
        issue(0, 1'b1, 32'h24, 32'h12345678, 4'h0, a);
        issue(0, 1'b0, 32'h24, 32'h0, 4'h0, a);
        issue(0, 1'b0, 32'h22, 32'h0, 4'hF, a);
        issue(0, 1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, a);
        issue(0, 1'b0, 32'h0, 32'h0, 4'h0, a);
        issue(0, 1'b0, 32'h3FC, 32'h0, 4'h0, a);

        for (int i = 0; i < 300; i++) begin
            ra = 32'($urandom_range(0, 'h47F));
            if ($urandom_range(0, 3) != 0) ra[1:0] = 2'b00;
            issue(0, 1'($urandom_range(0, 1)), ra, $urandom(), 4'($urandom_range(0, 15)), a);
        end

        issue(0, 1'b1, 32'h30, 32'hCAFEF00D, 4'hF, a);
        gen_dut[0].hold_req = 5;
        issue(0, 1'b0, 32'h30, 32'h0, 4'h0, a);

        issue(0, 1'b1, 32'h8, 32'h5A5A5A5A, 4'hF, a);
        rst_n = 1'b0;
        expq[0].delete();
        expq[1].delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        issue(0, 1'b0, 32'h8, 32'h0, 4'h0, a);

        for (int i = 0; i < 4; i++) issue(1, 1'b1, 32'(i * 4), $urandom(), 4'hF, a);
        for (int i = 0; i < 4; i++) issue(1, 1'b0, 32'(i * 4), 32'h0, 4'h0, accs[i]);
        for (int i = 1; i < 4; i++) chk("lat1_accept_spacing", 32'(accs[i] - accs[i-1]), 32'd2);

        for (int i = 0; i < 200; i++) begin
            if (expq[0].size() == 0 && expq[1].size() == 0) break;
            @(negedge clk);
        end
        if (expq[0].size() != 0 || expq[1].size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d/%0d responses outstanding, required 0/0", expq[0].size(), expq[1].size());
        end
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
